fwd_hazard_ctrl: RTL and testbench

//  Forwarding/hazard controller for the 5-stage pipeline. Tracks destination regs of
//  in-flight instructions (EX, MEM, WB) and produces registered 2-bit select codes for
//  the EX-stage 4:1 operand muxes (A, B). Detects load-use hazards: stalls IF/ID and

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/fwd_sel_pick.sv | 39 +++
 rtl/fwd_hazard_ctrl.sv | 89 ++++++++
 tb/tb_fwd_hazard_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and helpers for the pipeline forwarding/hazard control
package pipe_ctrl_pkg;

    localparam int PIPE_REG_W    = 5;
    localparam int PIPE_ZERO_REG = 31;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10,
        FWD_RET = 2'b11
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic [PIPE_REG_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } track_entry_t;

    // The zero register reads as constant zero, so it can never be a forwarding source.
    function automatic logic trk_match(
        input logic [PIPE_REG_W-1:0] src,
        input track_entry_t          e,
        input logic [PIPE_REG_W-1:0] zero_reg
    );
        return e.valid && e.reg_write && (e.rd == src) && (src != zero_reg);
    endfunction

endpackage

// File: rtl/fwd_sel_pick.sv
// rtl/fwd_sel_pick.sv - nearest-producer priority compare for one EX operand
module fwd_sel_pick
    import pipe_ctrl_pkg::*;
#(
    parameter int ZERO_REG = PIPE_ZERO_REG
) (
    input  logic [PIPE_REG_W-1:0] src,
    input  logic                  use_src,
    input  track_entry_t          ex_e,
    input  track_entry_t          mem_e,
    input  track_entry_t          wb_e,
    output fwd_sel_t              sel,
    output logic                  ex_hit
);

    localparam logic [PIPE_REG_W-1:0] ZR = PIPE_REG_W'(ZERO_REG);

    logic hit_ex;
    logic hit_mem;
    logic hit_wb;

    assign hit_ex  = use_src && trk_match(src, ex_e, ZR);
    assign hit_mem = use_src && trk_match(src, mem_e, ZR);
    assign hit_wb  = use_src && trk_match(src, wb_e, ZR);
    assign ex_hit  = hit_ex;

    // Codes name where the value sits one cycle later, when the consumer is in EX.
    always_comb begin
        sel = FWD_RF;
        if (hit_ex) begin
            sel = FWD_MEM;
        end else if (hit_mem) begin
            sel = FWD_WB;
        end else if (hit_wb) begin
            sel = FWD_RET;
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - operand forwarding selects and load-use stall control
module fwd_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W    = PIPE_REG_W,
    parameter int ZERO_REG = PIPE_ZERO_REG
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             flush,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b,
    output logic             stall,
    output logic             ex_bubble
);

    track_entry_t ex_q;
    track_entry_t mem_q;
    track_entry_t wb_q;
    track_entry_t id_entry;

    fwd_sel_t pick_a;
    fwd_sel_t pick_b;
    fwd_sel_t sel_a_q;
    fwd_sel_t sel_b_q;
    logic     ex_hit_a;
    logic     ex_hit_b;

    fwd_sel_pick #(.ZERO_REG(ZERO_REG)) u_pick_a (
        .src     (id_rn),
        .use_src (id_use_rn),
        .ex_e    (ex_q),
        .mem_e   (mem_q),
        .wb_e    (wb_q),
        .sel     (pick_a),
        .ex_hit  (ex_hit_a)
    );

    fwd_sel_pick #(.ZERO_REG(ZERO_REG)) u_pick_b (
        .src     (id_rm),
        .use_src (id_use_rm),
        .ex_e    (ex_q),
        .mem_e   (mem_q),
        .wb_e    (wb_q),
        .sel     (pick_b),
        .ex_hit  (ex_hit_b)
    );

    // A load in EX cannot supply its data until MEM, so a dependent in ID waits one cycle.
    assign stall     = id_valid && !flush && ex_q.valid && ex_q.mem_read && (ex_hit_a || ex_hit_b);
    assign ex_bubble = stall || flush;

    always_comb begin
        id_entry           = '0;
        id_entry.valid     = id_valid && !ex_bubble;
        id_entry.rd        = id_rd;
        id_entry.reg_write = id_reg_write;
        id_entry.mem_read  = id_mem_read;
    end

    // Tracking entries always advance; a stall only holds IF/ID, EX receives a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            sel_a_q <= FWD_RF;
            sel_b_q <= FWD_RF;
        end else begin
            ex_q    <= id_entry;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            sel_a_q <= ex_bubble ? FWD_RF : pick_a;
            sel_b_q <= ex_bubble ? FWD_RF : pick_b;
        end
    end

    assign fwd_sel_a = sel_a_q;
    assign fwd_sel_b = sel_b_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - self-checking bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic       id_use_rn;
    logic       id_use_rm;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       flush;
    logic [1:0] fwd_sel_a;
    logic [1:0] fwd_sel_b;
    logic       stall;
    logic       ex_bubble;

    int checks = 0;
    int errors = 0;

    fwd_hazard_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .id_valid     (id_valid),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_use_rn    (id_use_rn),
        .id_use_rm    (id_use_rm),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_sel_a    (fwd_sel_a),
        .fwd_sel_b    (fwd_sel_b),
        .stall        (stall),
        .ex_bubble    (ex_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the last three instructions issued into EX, youngest first.
    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit mr;
    } ins_t;

    ins_t hist [3];
    logic       exp_stall;
    logic       exp_bubble;
    logic [1:0] exp_a;
    logic [1:0] exp_b;

    function automatic int producer_age(input int src);
        for (int d = 0; d < 3; d++) begin
            if (hist[d].v && hist[d].rw && hist[d].rd == src && src != 31) return d;
        end
        return -1;
    endfunction

    function automatic logic [1:0] model_sel(input int src, input bit used, input bit bub);
        int age;
        age = producer_age(src);
        if (bub || !used || age < 0) return 2'd0;
        return 2'(age + 1);
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 3; d++) hist[d] = '{v: 0, rd: 0, rw: 0, mr: 0};
    endtask

    task automatic run_cycle(input logic v, input logic [4:0] rn, input logic [4:0] rm,
                             input logic urn, input logic urm, input logic [4:0] rd,
                             input logic rw, input logic mr, input logic fl,
                             output logic o_stall, output logic o_bub,
                             output logic [1:0] o_a, output logic [1:0] o_b);
        id_valid = v; id_rn = rn; id_rm = rm; id_use_rn = urn; id_use_rm = urm;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr; flush = fl;
        exp_stall  = v && !fl && hist[0].v && hist[0].mr &&
                     ((urn && producer_age(int'(rn)) == 0) || (urm && producer_age(int'(rm)) == 0));
        exp_bubble = exp_stall || fl;
        exp_a      = model_sel(int'(rn), urn, exp_bubble);
        exp_b      = model_sel(int'(rm), urm, exp_bubble);
        @(negedge clk);
        o_stall = stall;
        o_bub   = ex_bubble;
        @(posedge clk);
        #1;
        o_a = fwd_sel_a;
        o_b = fwd_sel_b;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = '{v: v && !exp_bubble, rd: int'(rd), rw: rw, mr: mr};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        id_valid = 0; id_rn = 0; id_rm = 0; id_use_rn = 0; id_use_rm = 0;
        id_rd = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++; if (ex_bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got %b want 0", ex_bubble); end
        checks++; if (fwd_sel_a !== 2'b00) begin errors++; $display("FAIL reset_sel_a got %b want 00", fwd_sel_a); end
        checks++; if (fwd_sel_b !== 2'b00) begin errors++; $display("FAIL reset_sel_b got %b want 00", fwd_sel_b); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic s, b;
        logic [1:0] a, bb;
        do_reset();
        run_cycle(1, 5'd2, 5'd3, 1, 1, 5'd1, 1, 0, 0, s, b, a, bb);
        run_cycle(1, 5'd1, 5'd3, 1, 1, 5'd2, 1, 0, 0, s, b, a, bb);
        checks++; if (a !== 2'b01) begin errors++; $display("FAIL b2b_sel_a got %b want 01", a); end
        checks++; if (bb !== 2'b00) begin errors++; $display("FAIL b2b_sel_b got %b want 00", bb); end
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b want 0", s); end
    endtask

    task automatic test_distance();
        logic s, b;
        logic [1:0] a, bb;
        logic [1:0] want;
        for (int gap = 1; gap <= 3; gap++) begin
            do_reset();
            run_cycle(1, 5'd2, 5'd3, 1, 1, 5'd1, 1, 0, 0, s, b, a, bb);
            for (int k = 0; k < gap; k++)
                run_cycle(1, 5'd11, 5'd12, 1, 1, 5'(10 + k), 1, 0, 0, s, b, a, bb);
            run_cycle(1, 5'd13, 5'd1, 1, 1, 5'd14, 1, 0, 0, s, b, a, bb);
            want = (gap == 1) ? 2'b10 : (gap == 2) ? 2'b11 : 2'b00;
            checks++; if (bb !== want) begin errors++; $display("FAIL dist%0d_sel_b got %b want %b", gap + 1, bb, want); end
            checks++; if (a !== 2'b00) begin errors++; $display("FAIL dist%0d_sel_a got %b want 00", gap + 1, a); end
        end
    endtask

    task automatic test_load_use();
        logic s, b;
        logic [1:0] a, bb;
        do_reset();
        run_cycle(1, 5'd9, 5'd0, 1, 0, 5'd5, 1, 1, 0, s, b, a, bb);
        run_cycle(1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0, s, b, a, bb);
        checks++; if (s !== 1'b1) begin errors++; $display("FAIL lu_stall got %b want 1", s); end
        checks++; if (b !== 1'b1) begin errors++; $display("FAIL lu_bubble got %b want 1", b); end
        checks++; if (a !== 2'b00) begin errors++; $display("FAIL lu_bubble_sel_a got %b want 00", a); end
        run_cycle(1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0, s, b, a, bb);
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL lu_stall_release got %b want 0", s); end
        checks++; if (b !== 1'b0) begin errors++; $display("FAIL lu_bubble_release got %b want 0", b); end
        checks++; if (a !== 2'b10) begin errors++; $display("FAIL lu_sel_a got %b want 10", a); end
    endtask

    task automatic test_priority_xzr();
        logic s, b;
        logic [1:0] a, bb;
        do_reset();
        run_cycle(1, 5'd2, 5'd3, 1, 1, 5'd4, 1, 0, 0, s, b, a, bb);
        run_cycle(1, 5'd2, 5'd3, 1, 1, 5'd4, 1, 0, 0, s, b, a, bb);
        run_cycle(1, 5'd4, 5'd4, 1, 1, 5'd8, 1, 0, 0, s, b, a, bb);
        checks++; if (a !== 2'b01) begin errors++; $display("FAIL prio_sel_a got %b want 01", a); end
        checks++; if (bb !== 2'b01) begin errors++; $display("FAIL prio_sel_b got %b want 01", bb); end
        run_cycle(1, 5'd2, 5'd3, 1, 1, 5'd31, 1, 0, 0, s, b, a, bb);
        run_cycle(1, 5'd31, 5'd2, 1, 1, 5'd9, 1, 0, 0, s, b, a, bb);
        checks++; if (a !== 2'b00) begin errors++; $display("FAIL xzr_sel_a got %b want 00", a); end
        run_cycle(1, 5'd2, 5'd0, 1, 0, 5'd31, 1, 1, 0, s, b, a, bb);
        run_cycle(1, 5'd31, 5'd31, 1, 1, 5'd9, 1, 0, 0, s, b, a, bb);
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL xzr_load_stall got %b want 0", s); end
        checks++; if (a !== 2'b00) begin errors++; $display("FAIL xzr_load_sel_a got %b want 00", a); end
    endtask

    task automatic test_flush();
        logic s, b;
        logic [1:0] a, bb;
        do_reset();
        run_cycle(1, 5'd9, 5'd0, 1, 0, 5'd5, 1, 1, 0, s, b, a, bb);
        run_cycle(1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 1, s, b, a, bb);
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL flush_stall got %b want 0", s); end
        checks++; if (b !== 1'b1) begin errors++; $display("FAIL flush_bubble got %b want 1", b); end
        checks++; if (a !== 2'b00) begin errors++; $display("FAIL flush_sel_a got %b want 00", a); end
        run_cycle(1, 5'd6, 5'd12, 1, 1, 5'd13, 1, 0, 0, s, b, a, bb);
        checks++; if (a !== 2'b00) begin errors++; $display("FAIL squashed_sel_a got %b want 00", a); end
        run_cycle(1, 5'd12, 5'd6, 1, 1, 5'd14, 1, 0, 0, s, b, a, bb);
        checks++; if (bb !== 2'b00) begin errors++; $display("FAIL squashed_sel_b got %b want 00", bb); end
    endtask

    task automatic test_reset_mid_stall();
        logic s, b;
        logic [1:0] a, bb;
        do_reset();
        run_cycle(1, 5'd9, 5'd0, 1, 0, 5'd5, 1, 1, 0, s, b, a, bb);
        id_rn = 5'd5; id_rm = 5'd7; id_use_rn = 1; id_use_rm = 1;
        id_rd = 5'd6; id_reg_write = 1; id_mem_read = 0; id_valid = 1; flush = 0;
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got %b want 1", stall); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        checks++; if (fwd_sel_a !== 2'b00) begin errors++; $display("FAIL rst_sel_a got %b want 00", fwd_sel_a); end
        run_cycle(1, 5'd5, 5'd7, 1, 1, 5'd6, 1, 0, 0, s, b, a, bb);
        checks++; if (s !== 1'b0) begin errors++; $display("FAIL rst_post_stall got %b want 0", s); end
        checks++; if (a !== 2'b00) begin errors++; $display("FAIL rst_empty_sel_a got %b want 00", a); end
    endtask

    function automatic logic [4:0] rand_reg();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 5'd31 : 5'(r);
    endfunction

    task automatic test_random();
        logic s, b;
        logic [1:0] a, bb;
        logic v, urn, urm, rw, mr, fl;
        logic [4:0] rn, rm, rd;
        bit held;
        held = 0;
        v = 0; urn = 0; urm = 0; rw = 0; mr = 0; rn = 0; rm = 0; rd = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (!held) begin
                v   = ($urandom_range(0, 7) != 0);
                rn  = rand_reg();
                rm  = rand_reg();
                rd  = rand_reg();
                urn = ($urandom_range(0, 3) != 0);
                urm = ($urandom_range(0, 3) != 0);
                mr  = ($urandom_range(0, 2) == 0);
                rw  = mr || ($urandom_range(0, 4) != 0);
            end
            fl = ($urandom_range(0, 9) == 0);
            run_cycle(v, rn, rm, urn, urm, rd, rw, mr, fl, s, b, a, bb);
            checks++; if (s !== exp_stall) begin errors++; $display("FAIL rnd%0d_stall got %b want %b", i, s, exp_stall); end
            checks++; if (b !== exp_bubble) begin errors++; $display("FAIL rnd%0d_bubble got %b want %b", i, b, exp_bubble); end
            checks++; if (a !== exp_a) begin errors++; $display("FAIL rnd%0d_sel_a got %b want %b", i, a, exp_a); end
            checks++; if (bb !== exp_b) begin errors++; $display("FAIL rnd%0d_sel_b got %b want %b", i, bb, exp_b); end
            held = exp_stall;
        end
    endtask

    initial begin
        reset = 1'b1;
        id_valid = 0; id_rn = 0; id_rm = 0; id_use_rn = 0; id_use_rm = 0;
        id_rd = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;
        model_clear();
        test_reset();
        test_back_to_back();
        test_distance();
        test_load_use();
        test_priority_xzr();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
